// File: rtl/sgpio_multi_shifter_if.sv
// Word handshake between the debug register logic (master) and the SGPIO serializer (slave).
interface sgpio_multi_shifter_if #(
  parameter int W = 32
) ();
  logic [W-1:0] i_data;
  logic         i_valid;
  logic         o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/sgpio_multi_shifter.sv
// Multi-channel SGPIO serializer with a one-deep shadow buffer.
// Optional macro SGPIO_REPEAT_EN: resend the last word while enabled and no new word waits.
module sgpio_multi_shifter #(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 4,
  parameter int CLK_DIV  = 500,
  parameter int GAP_BITS = 2
) (
  input  logic                  aclk,
  input  logic                  SGPIO_FPGA_DBG_RST_N,
  input  logic                  en,
  sgpio_multi_shifter_if.slave  bus,
  output logic                  o_sgpio_clk,
  output logic                  o_sgpio_data,
  output logic                  o_sgpio_load,
  output logic                  o_busy
);

  localparam int FRAME_BITS = NUM_CH * DATA_W;
  localparam int DIV_W      = $clog2(CLK_DIV);
  localparam int CNT_MAX    = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [FRAME_BITS-1:0]   shadow_q, shadow_d;
  logic                    shadow_full_q, shadow_full_d;
  logic [FRAME_BITS-1:0]   last_q, last_d;
  logic                    sclk_q, sclk_d;
  logic                    sdata_q, sdata_d;
  logic                    load_q, load_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;

  logic [FRAME_BITS-1:0]   in_vec;
  logic [FRAME_BITS-1:0]   start_vec;
  logic [DIV_W-1:0]        div_inc;
  logic                    hs;
  logic                    word_avail;
  logic                    start;

  // Channel 0 lands in the top slice so that plain MSB-first shifting emits ch0 first.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_reorder
      assign in_vec[(NUM_CH-1-gi)*DATA_W +: DATA_W] = bus.i_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign hs         = bus.i_valid && ready_q;
  assign word_avail = shadow_full_q || hs;
  assign div_inc    = div_q + DIV_W'(1);

`ifdef SGPIO_REPEAT_EN
  assign start_vec = shadow_full_q ? shadow_q : (hs ? in_vec : last_q);
`else
  assign start_vec = shadow_full_q ? shadow_q : in_vec;
`endif

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    last_d        = last_q;
    sclk_d        = sclk_q;
    sdata_d       = sdata_q;
    load_d        = load_q;
    start         = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && word_avail) start = 1'b1;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b0;
          load_d = 1'b0;
          if (cnt_q == FRAME_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
            sdata_d = 1'b0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
            sdata_d = shreg_q[FRAME_BITS-2];
          end
        end else begin
          div_d  = div_inc;
          sclk_d = (div_inc >= DIV_HALF);
        end
      end
      GAP: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (cnt_q == GAP_LAST) begin
`ifdef SGPIO_REPEAT_EN
            if (en) start = 1'b1;
`else
            if (en && word_avail) start = 1'b1;
`endif
            else state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          div_d = div_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = SHIFT;
      div_d   = '0;
      cnt_d   = '0;
      shreg_d = start_vec;
      sdata_d = start_vec[FRAME_BITS-1];
      load_d  = 1'b1;
      sclk_d  = 1'b0;
      last_d  = start_vec;
      if (shadow_full_q) shadow_full_d = 1'b0;
    end

    // Shadow is only ever written while empty: ready is low whenever it holds a word.
    if (hs && !start) begin
      shadow_d      = in_vec;
      shadow_full_d = 1'b1;
    end

    ready_d = !shadow_full_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge aclk or negedge SGPIO_FPGA_DBG_RST_N) begin
    if (!SGPIO_FPGA_DBG_RST_N) begin
      state_q       <= IDLE;
      div_q         <= '0;
      cnt_q         <= '0;
      shreg_q       <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      last_q        <= '0;
      sclk_q        <= 1'b0;
      sdata_q       <= 1'b0;
      load_q        <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      last_q        <= last_d;
      sclk_q        <= sclk_d;
      sdata_q       <= sdata_d;
      load_q        <= load_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
    end
  end

  assign o_sgpio_clk  = sclk_q;
  assign o_sgpio_data = sdata_q;
  assign o_sgpio_load = load_q;
  assign o_busy       = busy_q;
  assign bus.o_ready  = ready_q;

endmodule
